// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit CPU: word/address widths, instruction
// field positions and the boot program image restored on reset.
package cpu_isa_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 256;

  typedef logic [DATA_WIDTH-1:0] instr_t;
  typedef instr_t image_t [0:DEPTH-1];

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;

  localparam logic [3:0] OPC_HALT = 4'hF;

  // Everything past the HALT at address 4 is NOP (all zeros).
  localparam image_t BOOT_IMAGE = '{
    0:       16'h1123,
    1:       16'h2114,
    2:       16'h6104,
    3:       16'h7108,
    4:       16'hF000,
    default: 16'h0000
  };

  function automatic logic [3:0] get_opcode(input instr_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch/loader bus of the instruction memory: combinational read port plus a
// synchronous write port.
interface instruction_memory_if #(
  parameter int ADDR_WIDTH = cpu_isa_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_isa_pkg::DATA_WIDTH
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] instruction;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (
    output pc,
    output we,
    output waddr,
    output wdata,
    input  instruction
  );

  modport slave (
    input  pc,
    input  we,
    input  waddr,
    input  wdata,
    output instruction
  );

endinterface

// File: rtl/instruction_memory.sv
// 256 x 16 program store: zero-latency read at pc, rising-edge write port,
// asynchronous reset that reloads the boot image.
module instruction_memory #(
  parameter int ADDR_WIDTH = cpu_isa_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = cpu_isa_pkg::DATA_WIDTH,
  parameter int DEPTH      = cpu_isa_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_memory_if.slave  mem_if
);

  import cpu_isa_pkg::*;

  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_we;

  // Declaration init gives the boot image from time zero without a reset pulse.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1] = BOOT_IMAGE;

  assign w_raddr = mem_if.pc;
  assign w_waddr = mem_if.waddr;
  assign w_wdata = mem_if.wdata;
  assign w_we    = mem_if.we;

  // Reset reloads the whole image at once; writes only land while reset is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem <= BOOT_IMAGE;
    end else if (w_we == 1'b1) begin
      r_mem[w_waddr] <= w_wdata;
    end else if (w_we == 1'b0) begin
      r_mem[w_waddr] <= r_mem[w_waddr];
    end else begin
      // An unknown enable poisons only the addressed word.
      r_mem[w_waddr] <= {DATA_WIDTH{1'bx}};
    end
  end

  // Read is a pure array lookup, so no bypass of wdata on pc == waddr.
  assign mem_if.instruction = r_mem[w_raddr];

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: directed boot/reset/write checks
// followed by randomized write/read traffic against a behavioural model.
module tb_instruction_memory;

  logic clk;
  logic reset;

  instruction_memory_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) mem_if();

  instruction_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .DEPTH(256)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mem_if.slave)
  );

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  sb_item_t    mon_it;
  event        push_ev;
  logic [15:0] model_mem [0:255];
  int          vectors     = 0;
  int          miscompares = 0;

  function automatic logic [15:0] boot_word(input int a);
    case (a)
      0:       return 16'h1123;
      1:       return 16'h2114;
      2:       return 16'h6104;
      3:       return 16'h7108;
      4:       return 16'hF000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) model_mem[i] = boot_word(i);
  endtask

  task automatic push(input string nm, input logic [15:0] exp);
    sb_item_t it;
    it.name = nm;
    it.exp  = exp;
    sb_q.push_back(it);
    -> push_ev;
    #2;
  endtask

  task automatic expect_const(input string nm, input logic [15:0] exp);
    push(nm, exp);
  endtask

  task automatic expect_model(input string nm);
    push(nm, model_mem[mem_if.pc]);
  endtask

  task automatic rise();
    clk = 1'b1;
    if (!reset && mem_if.we) model_mem[mem_if.waddr] = mem_if.wdata;
  endtask

  task automatic write_cycle(input logic [7:0] a, input logic [15:0] d);
    mem_if.we    = 1'b1;
    mem_if.waddr = a;
    mem_if.wdata = d;
    #2;
    rise();
    #3;
    clk = 1'b0;
    #2;
  endtask

  // Monitor: samples instruction 1 unit after each expectation is queued.
  initial begin
    forever begin
      @(push_ev);
      while (sb_q.size() > 0) begin
        #1;
        mon_it = sb_q.pop_front();
        vectors++;
        if (mem_if.instruction !== mon_it.exp) begin
          miscompares++;
          $display("FAIL %s: instruction=%h expected=%h (pc=%0d t=%0t)",
                   mon_it.name, mem_if.instruction, mon_it.exp, mem_if.pc, $time);
        end
      end
    end
  end

  initial begin
    logic [15:0] boot_exp [0:4];
    boot_exp[0] = 16'h1123;
    boot_exp[1] = 16'h2114;
    boot_exp[2] = 16'h6104;
    boot_exp[3] = 16'h7108;
    boot_exp[4] = 16'hF000;

    clk          = 1'b0;
    reset        = 1'b0;
    mem_if.pc    = 8'd0;
    mem_if.we    = 1'b0;
    mem_if.waddr = 8'd0;
    mem_if.wdata = 16'h0000;
    model_reset();

    // Boot image visible without any reset or clock.
    #10;
    expect_const("boot_pc0", boot_exp[0]);
    for (int i = 1; i < 5; i++) begin
      #8;
      mem_if.pc = 8'(i);
      expect_const($sformatf("boot_pc%0d", i), boot_exp[i]);
    end
    mem_if.pc = 8'd5;
    expect_const("nop_pc5", 16'h0000);
    mem_if.pc = 8'd255;
    expect_const("nop_pc255", 16'h0000);

    // Read-during-write: old word before the edge, new word right after.
    mem_if.pc    = 8'd2;
    mem_if.we    = 1'b1;
    mem_if.waddr = 8'd2;
    mem_if.wdata = 16'hABCD;
    expect_const("rdw_before", 16'h6104);
    rise();
    expect_const("rdw_after", 16'hABCD);
    #3;
    clk = 1'b0;
    mem_if.we    = 1'b0;
    mem_if.wdata = 16'h1111;
    #2;
    rise();
    expect_const("we0_hold", 16'hABCD);
    #3;
    clk = 1'b0;
    #2;

    // Mid-cycle reset restores the image without a clock edge.
    reset = 1'b1;
    model_reset();
    expect_const("reset_async", 16'h6104);
    mem_if.pc    = 8'd0;
    mem_if.we    = 1'b1;
    mem_if.waddr = 8'd0;
    mem_if.wdata = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      #2;
      rise();
      #3;
      clk = 1'b0;
    end
    expect_const("reset_blocks_write", 16'h1123);
    reset = 1'b0;
    expect_const("reset_release", 16'h1123);

    // Boundary addresses on consecutive edges.
    write_cycle(8'd255, 16'h5A5A);
    write_cycle(8'd0, 16'h0F0F);
    mem_if.we = 1'b0;
    mem_if.pc = 8'd255;
    expect_const("wr_pc255", 16'h5A5A);
    mem_if.pc = 8'd0;
    expect_const("wr_pc0", 16'h0F0F);
    mem_if.pc = 8'd1;
    expect_const("wr_pc1_untouched", 16'h2114);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 150; n++) begin
      mem_if.we    = 1'($urandom_range(0, 1));
      mem_if.waddr = 8'($urandom);
      mem_if.wdata = 16'($urandom);
      if ($urandom_range(0, 2) == 0) mem_if.pc = mem_if.waddr;
      else                           mem_if.pc = 8'($urandom);
      #2;
      expect_model("rnd_pre_edge");
      rise();
      expect_model("rnd_post_edge");
      #3;
      clk = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        model_reset();
        expect_model("rnd_reset");
        reset = 1'b0;
      end
      #2;
    end

    for (int t = 0; t < 100 && sb_q.size() > 0; t++) #1;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
